// File: rtl/prescaler_pkg.sv
// -----------------------------------------------------------------------------
// prescaler_pkg
// Shared constants and helpers for the prescaler bank.
//   DEFAULT_NUM_CH / DEFAULT_CNT_W / DEFAULT_DIV : default top-level parameters
//   MIN_DIV   : smallest usable divisor; a requested divisor of 1 runs as this
//   ch_idx_w(): width of the channel-select field (never less than 1 bit)
// -----------------------------------------------------------------------------
package prescaler_pkg;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_CNT_W  = 16;
  localparam int DEFAULT_DIV    = 400;
  localparam int MIN_DIV        = 2;

  // A one-channel bank still needs a 1-bit select port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/prescaler_channel.sv
// -----------------------------------------------------------------------------
// prescaler_channel
// One clock-divider channel: counts 0..D-1 and wraps, where D is the active
// divisor. A new divisor is parked in a pending slot and only becomes active at
// a period boundary, so no clockOut phase is ever shortened. D=0 disables the
// channel (outputs low, count held at 0); D=1 runs as D=2.
//
// Optional feature (macro PRESCALER_SYNC_EN): i_sync forces a period boundary
// (count restarts at 0, any pending divisor is applied).
//
// Ports
//   clockIn      : clock
//   resetN       : asynchronous active-low reset
//   i_load_en    : store i_load_div into the pending slot this edge
//   i_load_div   : divisor to store
//   i_sync       : restart pulse (PRESCALER_SYNC_EN only)
//   o_pend_valid : pending slot occupied
//   o_clk        : divided clock, registered
//   o_tick       : one-cycle pulse in the last cycle of each period, registered
// -----------------------------------------------------------------------------
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int DIV_RESET = DEFAULT_DIV
) (
  input  logic             clockIn,
  input  logic             resetN,
  input  logic             i_load_en,
  input  logic [CNT_W-1:0] i_load_div,
`ifdef PRESCALER_SYNC_EN
  input  logic             i_sync,
`endif
  output logic             o_pend_valid,
  output logic             o_clk,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_clk;
  logic             r_tick;

  logic             w_bound;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_pend_valid_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;

  // Next state is computed as a whole so the output registers are derived from
  // the same count/divisor that the counter registers will hold next cycle;
  // that keeps clockOut/tick exactly aligned with the count they describe.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise a path
    // that skips an assignment would infer a latch.
    w_count_nxt      = r_count + ONE;
    w_div_nxt        = r_div;
    w_pend_valid_nxt = r_pend_valid;

    // A disabled channel has no period, so every cycle is a boundary.
    w_bound = (r_div == '0) || (r_count == r_div - ONE);
`ifdef PRESCALER_SYNC_EN
    w_bound = w_bound || i_sync;
`endif

    if (w_bound) begin
      w_count_nxt = '0;
      if (r_pend_valid) begin
        w_div_nxt        = (r_pend == ONE) ? CNT_W'(MIN_DIV) : r_pend;
        w_pend_valid_nxt = 1'b0;
      end
    end

    // A load is only ever accepted into an empty slot, so it never collides
    // with the apply above; it simply refills the slot for the next boundary.
    if (i_load_en) begin
      w_pend_valid_nxt = 1'b1;
    end

    w_clk_nxt  = (w_div_nxt != '0) && (w_count_nxt >= (w_div_nxt >> 1));
    w_tick_nxt = (w_div_nxt != '0) && (w_count_nxt == w_div_nxt - ONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      r_count      <= '0;
      r_div        <= CNT_W'(DIV_RESET);
      // NOTE: the pending data is reset along with its valid bit; it is a
      // single register, not a memory, and resetting it keeps state fully
      // defined after reset at negligible cost.
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_clk        <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_div        <= w_div_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_clk        <= w_clk_nxt;
      r_tick       <= w_tick_nxt;
      if (i_load_en) begin
        r_pend <= i_load_div;
      end
    end
  end

  assign o_pend_valid = r_pend_valid;
  assign o_clk        = r_clk;
  assign o_tick       = r_tick;

endmodule

// File: rtl/prescaler_bank.sv
// -----------------------------------------------------------------------------
// prescaler_bank
// NUM_CH independent programmable clock dividers sharing one load port.
// A load (loadValid && loadReady) targets channel loadChannel; loads to a
// channel index >= NUM_CH are accepted and dropped.
//
// Optional feature (macro PRESCALER_SYNC_EN): adds syncIn, which restarts every
// channel at count 0 and applies pending divisors, phase-aligning all outputs.
//
// Ports
//   clockIn     : clock (100 MHz)
//   resetN      : asynchronous active-low reset
//   loadValid   : divisor load request
//   loadReady   : target channel can take a load (0 during reset)
//   loadChannel : target channel of the load
//   loadDivisor : new divisor
//   syncIn      : restart pulse (PRESCALER_SYNC_EN only)
//   clockOut    : divided clock per channel
//   tick        : end-of-period pulse per channel
// -----------------------------------------------------------------------------
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter  int NUM_CH    = DEFAULT_NUM_CH,
  parameter  int CNT_W     = DEFAULT_CNT_W,
  parameter  int DIV_RESET = DEFAULT_DIV,
  localparam int IDX_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clockIn,
  input  logic              resetN,
  input  logic              loadValid,
  output logic              loadReady,
  input  logic [IDX_W-1:0]  loadChannel,
  input  logic [CNT_W-1:0]  loadDivisor,
`ifdef PRESCALER_SYNC_EN
  input  logic              syncIn,
`endif
  output logic [NUM_CH-1:0] clockOut,
  output logic [NUM_CH-1:0] tick
);

  logic              r_ready;
  logic [NUM_CH-1:0] w_pend_valid;
  logic [NUM_CH-1:0] w_load_en;

  // Holds loadReady low through reset and releases it on the first edge after.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // Out-of-range channels match no entry and therefore stay ready.
  always_comb begin
    loadReady = r_ready;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((loadChannel == IDX_W'(c)) && w_pend_valid[c]) begin
        loadReady = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_load_en[c] = loadValid && loadReady && (loadChannel == IDX_W'(c));

    prescaler_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_channel (
      .clockIn      (clockIn),
      .resetN       (resetN),
      .i_load_en    (w_load_en[c]),
      .i_load_div   (loadDivisor),
`ifdef PRESCALER_SYNC_EN
      .i_sync       (syncIn),
`endif
      .o_pend_valid (w_pend_valid[c]),
      .o_clk        (clockOut[c]),
      .o_tick       (tick[c])
    );
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// -----------------------------------------------------------------------------
// tb_prescaler_bank
// Self-checking bench for prescaler_bank. Three channels are instantiated so
// that loadChannel=3 exercises the out-of-range load path. A per-channel
// reference model (position within period, active divisor, pending slot) is
// advanced every rising edge and compared against clockOut/tick/loadReady.
// Define PRESCALER_SYNC_EN to also exercise the syncIn restart.
// -----------------------------------------------------------------------------
module tb_prescaler_bank;
  import prescaler_pkg::*;

  localparam int NUM_CH    = 3;
  localparam int CNT_W     = 16;
  localparam int DIV_RESET = 400;
  localparam int IDX_W     = ch_idx_w(NUM_CH);

  logic              clockIn     = 1'b0;
  logic              resetN      = 1'b1;
  logic              loadValid   = 1'b0;
  logic              loadReady;
  logic [IDX_W-1:0]  loadChannel = '0;
  logic [CNT_W-1:0]  loadDivisor = '0;
  logic [NUM_CH-1:0] clockOut;
  logic [NUM_CH-1:0] tick;
`ifdef PRESCALER_SYNC_EN
  logic              syncIn      = 1'b0;
`endif

  always #5 clockIn = ~clockIn;

  prescaler_bank #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clockIn     (clockIn),
    .resetN      (resetN),
    .loadValid   (loadValid),
    .loadReady   (loadReady),
    .loadChannel (loadChannel),
    .loadDivisor (loadDivisor),
`ifdef PRESCALER_SYNC_EN
    .syncIn      (syncIn),
`endif
    .clockOut    (clockOut),
    .tick        (tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pos  [NUM_CH];  // cycles elapsed in the current period
  int m_div  [NUM_CH];  // active divisor, 0 = disabled
  int m_pend [NUM_CH];
  bit m_pv   [NUM_CH];
  bit m_ready;
  bit last_acc;

  function automatic bit sync_level();
`ifdef PRESCALER_SYNC_EN
    return syncIn;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_div[c] = DIV_RESET; m_pend[c] = 0; m_pv[c] = 0;
    end
    m_ready  = 0;
    last_acc = 0;
  endtask

  function automatic bit exp_ready(input int ch);
    if (!m_ready) return 1'b0;
    if (ch >= NUM_CH) return 1'b1;
    return !m_pv[ch];
  endfunction

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_div[c] != 0) && (m_pos[c] >= m_div[c] / 2);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_div[c] != 0) && (m_pos[c] == m_div[c] - 1);
    return v;
  endfunction

  task automatic model_edge(input bit valid, input int ch, input int d, input bit sync);
    bit acc;
    acc = valid && exp_ready(ch);
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_div[c] == 0 || m_pos[c] == m_div[c] - 1 || sync) begin
        m_pos[c] = 0;
        if (m_pv[c]) begin
          m_div[c] = (m_pend[c] == 1) ? 2 : m_pend[c];
          m_pv[c]  = 0;
        end
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
    end
    if (acc && ch < NUM_CH) begin
      m_pend[ch] = d;
      m_pv[ch]   = 1;
    end
    m_ready  = 1;
    last_acc = acc;
  endtask

  // One clock cycle: inputs were set at the preceding negedge; outputs are
  // compared at the following negedge.
  task automatic step();
    #1;
    check("loadReady", loadReady, exp_ready(int'(loadChannel)));
    @(posedge clockIn);
    if (!resetN) model_reset();
    else model_edge(loadValid, int'(loadChannel), int'(loadDivisor), sync_level());
    @(negedge clockIn);
    check("clockOut", clockOut, exp_clk());
    check("tick", tick, exp_tick());
  endtask

  task automatic steps_until_tick(input int c, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (tick[c]) begin n = i; break; end
    end
  endtask

  task automatic measure_period(input int c, output int p);
    int a;
    steps_until_tick(c, 1000, a);
    if (a < 0) p = -1;
    else steps_until_tick(c, 1000, p);
  endtask

  task automatic load_once(input int ch, input int d);
    loadChannel = IDX_W'(ch); loadDivisor = CNT_W'(d); loadValid = 1'b1;
    step();
    loadValid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, p, highs, ticks, stalls, first_co, second_co;

    // ---- reset, then free-running at DIV_RESET ----
    model_reset();
    #2 resetN = 1'b0;
    repeat (3) step();
    check("rst_clockOut", clockOut, '0);
    check("rst_tick", tick, '0);
    resetN = 1'b1;
    steps_until_tick(0, 1000, n);
    check("first_tick_cycle", n + 1, 400);
    check("first_tick_all", tick, 3'b111);

    // out-of-range load: accepted, no effect
    loadChannel = 2'd3; loadDivisor = 16'd7; loadValid = 1'b1;
    #1 check("oor_ready", loadReady, 1'b1);
    step();
    loadValid = 1'b0; loadChannel = '0;

    // ---- ch1 <- 5 at count 100 ----
    repeat (100) step();
    check("ch1_pos_before_load", m_pos[1], 100);
    load_once(1, 5);
    measure_period(1, p);
    check("ch1_period", p, 5);
    highs = 0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(); highs += int'(clockOut[1]); ticks += int'(tick[1]);
    end
    check("ch1_high_in_10", highs, 6);
    check("ch1_ticks_in_10", ticks, 2);
    measure_period(0, p);
    check("ch0_period_unchanged", p, 400);

    // ---- ch2: back-to-back loads ----
    load_once(2, 7);
    loadChannel = 2'd2; loadDivisor = 16'd9; loadValid = 1'b1;
    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (last_acc) break;
      stalls++;
    end
    loadValid = 1'b0;
    check("ch2_second_accepted", last_acc, 1'b1);
    check("ch2_stalled", stalls > 0, 1'b1);
    measure_period(2, p);
    check("ch2_period_after", p, 9);

    // ---- ch0 disable, then re-enable ----
    load_once(0, 0);
    repeat (420) step();
    highs = 0; ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(); highs += int'(clockOut[0]); ticks += int'(tick[0]);
    end
    check("ch0_off_high", highs, 0);
    check("ch0_off_ticks", ticks, 0);
    load_once(0, 10);
    steps_until_tick(0, 50, n);
    check("ch0_first_tick_after_enable", n, 10);
    steps_until_tick(0, 50, n);
    check("ch0_period_10", n, 10);

    // ---- reset mid-period with a pending load ----
    for (int i = 0; i < 20 && m_pos[2] != 1; i++) step();
    load_once(2, 4);
    step();
    check("ch2_pending_before_reset", m_pv[2], 1'b1);
    #2 resetN = 1'b0;
    #1 model_reset();
    check("midrst_clockOut", clockOut, '0);
    check("midrst_tick", tick, '0);
    check("midrst_ready", loadReady, 1'b0);
    @(negedge clockIn);
    repeat (2) step();
    resetN = 1'b1;
    steps_until_tick(2, 1000, n);
    check("ch2_restart_tick_cycle", n + 1, 400);

`ifdef PRESCALER_SYNC_EN
    // ---- sync alignment ----
    load_once(0, 6);
    load_once(1, 9);
    syncIn = 1'b1; loadChannel = 2'd2; loadDivisor = 16'd11; loadValid = 1'b1;
    step();
    syncIn = 1'b0; loadValid = 1'b0;
    check("sync_clk", clockOut[1:0], 2'b00);
    check("sync_tick", tick[1:0], 2'b00);
    #1 check("sync_load_kept_pending", loadReady, 1'b0);
    first_co = -1; second_co = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick[0] && tick[1]) begin
        if (first_co < 0) first_co = k;
        else if (second_co < 0) second_co = k;
      end
    end
    check("sync_first_coincide", first_co, 17);
    check("sync_coincide_gap", second_co - first_co, 18);
`endif

    // ---- randomized loads ----
    for (int i = 0; i < 2500; i++) begin
      loadValid   = ($urandom_range(0, 9) < 3);
      loadChannel = IDX_W'($urandom_range(0, 3));
      loadDivisor = CNT_W'($urandom_range(0, 12));
`ifdef PRESCALER_SYNC_EN
      syncIn      = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
    loadValid = 1'b0;
`ifdef PRESCALER_SYNC_EN
    syncIn = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
